// File: rtl/logic_pipe.sv
// Two-stage valid/ready bitwise-logic pipeline: stage 1 combines a/b and c/d,
// stage 2 combines those results; counts completed output handshakes.
module logic_pipe #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    input  logic [WIDTH-1:0]   in_d,
    input  logic [5:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_q,
    output logic [COUNT_W-1:0] xfer_count
);

    function automatic logic [WIDTH-1:0] lane_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            2'b11:   r = ~(a & b);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic               s1_valid_r;
    logic [WIDTH-1:0]   s1_x_r;
    logic [WIDTH-1:0]   s1_y_r;
    logic [1:0]         s1_op_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_q_r;
    logic [COUNT_W-1:0] count_r;

    logic s2_free_s;
    logic s1_adv_s;
    logic accept_s;
    logic out_fire_s;

    // Handshake decode; flush blocks acceptance so it cannot collide with a capture.
    always_comb begin
        s2_free_s  = ~out_valid_r | out_ready;
        s1_adv_s   = s1_valid_r & s2_free_s;
        in_ready   = ~flush & (~s1_valid_r | s2_free_s);
        accept_s   = in_valid & in_ready;
        out_fire_s = out_valid_r & out_ready;
    end

    // Stage 1 capture and valid tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= '0;
            s1_y_r     <= '0;
            s1_op_r    <= 2'b00;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_x_r     <= lane_op(in_mode[1:0], in_a, in_b);
            s1_y_r     <= lane_op(in_mode[3:2], in_c, in_d);
            s1_op_r    <= in_mode[5:4];
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Output stage: result holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_q_r     <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            out_valid_r <= 1'b1;
            out_q_r     <= lane_op(s1_op_r, s1_x_r, s1_y_r);
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Handshake counter; a handshake in a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (out_fire_s) begin
            count_r <= count_r + COUNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_q      = out_q_r;
    assign xfer_count = count_r;

endmodule
